// File: rtl/leaf_rr_scheduler.sv
// leaf_rr_scheduler: round-robin arbiter that hands one shared resource to
// one of N_REQ leaf requesters at a time. A grant lasts until the owner
// pulses done, drops its request, or holds it for TIMEOUT cycles. Every
// grant is followed by one RELEASE cycle and one IDLE cycle before the
// next grant can be issued.
module leaf_rr_scheduler #(
    parameter int N_REQ   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [2:0]       gnt_id,
    output logic             timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0]       CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0]       ID_LAST  = 3'(N_REQ - 1);
    localparam logic [N_REQ-1:0] GNT_ONE  = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] cnt;

    logic       found;
    logic [2:0] winner;
    logic [3:0] cand;
    logic       release_now;
    logic [2:0] next_ptr;

    // Pick the first requester at or above ptr, wrapping past the top index.
    always_comb begin
        found  = 1'b0;
        winner = 3'd0;
        cand   = 4'd0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + 4'(i);
            if (cand >= 4'(N_REQ)) begin
                cand = cand - 4'(N_REQ);
            end
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand[2:0];
            end
        end
    end

    // The owner gives up the grant with done or by dropping its request;
    // the next search starts one past it.
    always_comb begin
        release_now = done[gnt_id] | ~req[gnt_id];
        next_ptr    = (gnt_id == ID_LAST) ? 3'd0 : gnt_id + 3'd1;
    end

    // Arbitration state machine with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= 3'd0;
            cnt           <= 8'd0;
            gnt           <= '0;
            gnt_valid     <= 1'b0;
            gnt_id        <= 3'd0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= GRANT;
                        gnt       <= GNT_ONE << winner;
                        gnt_valid <= 1'b1;
                        gnt_id    <= winner;
                        cnt       <= 8'd0;
                    end
                end
                GRANT: begin
                    if (release_now || cnt == CNT_LAST) begin
                        state         <= RELEASE;
                        ptr           <= next_ptr;
                        gnt           <= '0;
                        gnt_valid     <= 1'b0;
                        gnt_id        <= 3'd0;
                        cnt           <= 8'd0;
                        timeout_pulse <= ~release_now;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leaf_rr_scheduler.sv
// tb_leaf_rr_scheduler: scoreboard bench for leaf_rr_scheduler. A cycle
// model predicts the registered outputs for each driven cycle; directed
// checks cover grant order, grant length, timeout pulses and reset.
module tb_leaf_rr_scheduler;

    localparam int N_REQ   = 5;
    localparam int TIMEOUT = 16;

    logic             clk;
    logic             rst;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
    logic [2:0]       gnt_id;
    logic             timeout_pulse;

    leaf_rr_scheduler #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .done         (done),
        .gnt          (gnt),
        .gnt_valid    (gnt_valid),
        .gnt_id       (gnt_id),
        .timeout_pulse(timeout_pulse)
    );

    typedef struct {
        logic [N_REQ-1:0] gnt;
        logic             valid;
        logic [2:0]       id;
        logic             tp;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];

    int n_checks = 0;
    int n_fail   = 0;

    int m_state;
    int m_ptr;
    int m_cnt;
    int m_id;
    logic [N_REQ-1:0] m_gnt;

    logic prev_valid;
    int   run_len;
    int   last_len;
    int   tp_count;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something never returns.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic modelReset();
        m_state = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_id    = 0;
        m_gnt   = '0;
    endtask

    task automatic modelStep(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] d);
        exp_t e;
        bit   tp;
        bit   hit;
        int   c;
        tp = 1'b0;
        case (m_state)
            0: begin
                if (r != '0) begin
                    hit = 1'b0;
                    for (int k = 0; k < N_REQ; k++) begin
                        c = (m_ptr + k) % N_REQ;
                        if (!hit && r[c]) begin
                            hit  = 1'b1;
                            m_id = c;
                        end
                    end
                    m_gnt   = 5'b00001 << m_id;
                    m_cnt   = 0;
                    m_state = 1;
                end
            end
            1: begin
                if (d[m_id] || !r[m_id] || m_cnt == TIMEOUT - 1) begin
                    tp      = !(d[m_id] || !r[m_id]);
                    m_ptr   = (m_id + 1) % N_REQ;
                    m_state = 2;
                    m_gnt   = '0;
                    m_id    = 0;
                end else begin
                    m_cnt++;
                end
            end
            default: m_state = 0;
        endcase
        e.gnt   = m_gnt;
        e.valid = (m_gnt != '0);
        e.id    = 3'(m_id);
        e.tp    = tp;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs from a negedge, then compare after the edge.
    task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] d);
        exp_t e;
        req  = r;
        done = d;
        modelStep(r, d);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            checkOutput("gnt", 32'(gnt), 32'(e.gnt));
            checkOutput("gnt_valid", 32'(gnt_valid), 32'(e.valid));
            checkOutput("gnt_id", 32'(gnt_id), 32'(e.id));
            checkOutput("timeout_pulse", 32'(timeout_pulse), 32'(e.tp));
        end
        if (gnt_valid && !prev_valid) grant_log.push_back(int'(gnt_id));
        if (gnt_valid) begin
            run_len++;
        end else if (prev_valid) begin
            last_len = run_len;
            run_len  = 0;
        end
        if (timeout_pulse) tp_count++;
        prev_valid = gnt_valid;
        @(negedge clk);
    endtask

    // Assert reset at a negedge, check the outputs drop at once, release at next negedge.
    task automatic resetDut();
        rst  = 1'b1;
        req  = '0;
        done = '0;
        #1;
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_gnt_valid", 32'(gnt_valid), 32'd0);
        checkOutput("rst_gnt_id", 32'(gnt_id), 32'd0);
        checkOutput("rst_timeout_pulse", 32'(timeout_pulse), 32'd0);
        modelReset();
        exp_q.delete();
        grant_log.delete();
        prev_valid = 1'b0;
        run_len    = 0;
        last_len   = 0;
        tp_count   = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int exp_order[6];
        logic [N_REQ-1:0] d;
        int got_id;

        rst  = 1'b1;
        req  = '0;
        done = '0;
        @(negedge clk);
        @(negedge clk);
        resetDut();

        // Idle with no requests.
        for (int i = 0; i < 3; i++) applyStimulus(5'b00000, 5'b00000);

        // Single requester, done three cycles into the grant, request kept.
        applyStimulus(5'b00100, 5'b00000);
        checkOutput("single_first_gnt", 32'(gnt), 32'h04);
        applyStimulus(5'b00100, 5'b00000);
        applyStimulus(5'b00100, 5'b00000);
        applyStimulus(5'b00100, 5'b00100);
        applyStimulus(5'b00100, 5'b00000);
        applyStimulus(5'b00100, 5'b00000);
        applyStimulus(5'b00100, 5'b00000);
        checkOutput("single_len", 32'(last_len), 32'd3);
        checkOutput("single_id", 32'(grant_log.size() > 0 ? grant_log[0] : 7), 32'd2);
        checkOutput("single_regrant", 32'(grant_log.size()), 32'd2);

        // Round robin with all requesting, each grant released in its first cycle.
        resetDut();
        for (int i = 0; i < 20; i++) begin
            d = (m_state == 1) ? (5'b00001 << m_id) : 5'b00000;
            applyStimulus(5'b11111, d);
        end
        exp_order = '{0, 1, 2, 3, 4, 0};
        for (int k = 0; k < 6; k++) begin
            got_id = (k < grant_log.size()) ? grant_log[k] : 7;
            checkOutput($sformatf("rr_order_%0d", k), 32'(got_id), 32'(exp_order[k]));
        end

        // Timeout: a single held request with no done.
        resetDut();
        for (int i = 0; i < 22; i++) applyStimulus(5'b00001, 5'b00000);
        checkOutput("timeout_len", 32'(last_len), 32'd16);
        checkOutput("timeout_pulses", 32'(tp_count), 32'd1);
        checkOutput("timeout_regrants", 32'(grant_log.size()), 32'd2);
        checkOutput("timeout_regrant_id", 32'(grant_log.size() > 1 ? grant_log[1] : 7), 32'd0);

        // Done arriving on the last counted cycle beats the timeout.
        resetDut();
        applyStimulus(5'b00010, 5'b00000);
        for (int i = 0; i < 15; i++) applyStimulus(5'b00010, 5'b00000);
        applyStimulus(5'b00010, 5'b00010);
        applyStimulus(5'b00000, 5'b00000);
        applyStimulus(5'b00000, 5'b00000);
        checkOutput("collision_len", 32'(last_len), 32'd16);
        checkOutput("collision_tp", 32'(tp_count), 32'd0);

        // Stray done from a non-owner, then reset in the middle of a grant.
        resetDut();
        applyStimulus(5'b01000, 5'b00000);
        applyStimulus(5'b01000, 5'b01000);
        applyStimulus(5'b00000, 5'b00000);
        applyStimulus(5'b00010, 5'b00000);
        applyStimulus(5'b00010, 5'b00000);
        checkOutput("wrap_grant_id", 32'(gnt_id), 32'd1);
        applyStimulus(5'b00010, 5'b01000);
        checkOutput("stray_hold", 32'(gnt), 32'h02);
        applyStimulus(5'b00010, 5'b00000);
        resetDut();
        applyStimulus(5'b10001, 5'b00000);
        checkOutput("post_reset_id", 32'(gnt_id), 32'd0);
        applyStimulus(5'b10001, 5'b00001);
        applyStimulus(5'b10000, 5'b00000);
        applyStimulus(5'b10000, 5'b00000);
        checkOutput("post_reset_next_id", 32'(gnt_id), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/leaf_rr_scheduler.md
LEAF_RR_SCHEDULER -- requirements
Module: leaf_rr_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 5: number of requesters; the five leaf instances of the sa9 level share one resource.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum grant length in cycles, legal range 2..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req, input, N_REQ bits: level request per requester.
REQ-006 SHALL have port done, input, N_REQ bits: one-cycle release pulse per requester.
REQ-007 SHALL have port gnt, output, N_REQ bits: one-hot grant, registered.
REQ-008 SHALL have port gnt_valid, output, 1 bit: high exactly when gnt is nonzero.
REQ-009 SHALL have port gnt_id, output, 3 bits: index of the granted requester; 0 when gnt_valid is low.
REQ-010 SHALL have port timeout_pulse, output, 1 bit: one-cycle pulse when a grant is revoked by timeout.

Function
REQ-011 SHALL implement a state machine with states IDLE, GRANT and RELEASE.
REQ-012 In IDLE with req nonzero at edge t, SHALL enter GRANT with gnt registered at t+1 (one-cycle latency).
REQ-013 In IDLE, the winner SHALL be the first set bit of req searching upward from ptr, wrapping N_REQ-1 to 0.
REQ-014 In IDLE with req all zero, SHALL stay in IDLE with gnt=0.
REQ-015 In GRANT, gnt SHALL hold constant; cnt SHALL increment by 1 per cycle, starting from 0 on the first grant cycle.
REQ-016 In GRANT, done[gnt_id]=1 SHALL cause transition to RELEASE at the next edge.
REQ-017 In GRANT, req[gnt_id]=0 SHALL be treated identically to done.
REQ-018 In GRANT, done bits of non-granted requesters SHALL be ignored.
REQ-019 In GRANT, when cnt==TIMEOUT-1 and no release is present, SHALL go to RELEASE and assert timeout_pulse for exactly the first RELEASE cycle.
REQ-020 When release and timeout occur in the same cycle, release SHALL win and timeout_pulse SHALL stay 0.
REQ-021 In RELEASE, gnt SHALL be 0; ptr SHALL load (gnt_id+1) mod N_REQ, so 4 wraps to 0; next state SHALL be IDLE.
REQ-022 Minimum spacing between grants SHALL be 2 idle-grant cycles (RELEASE, then IDLE); back-to-back grants are never adjacent.
REQ-023 Requests arriving during GRANT or RELEASE SHALL be arbitrated only in IDLE, using the updated ptr.
REQ-024 gnt SHALL never have more than one bit set.

Reset
REQ-025 While rst=1, SHALL force state=IDLE, ptr=0, cnt=0, gnt=0, gnt_valid=0, gnt_id=0, timeout_pulse=0, asynchronously.
REQ-026 Assertion of rst mid-GRANT SHALL drop gnt immediately without a timeout_pulse.
REQ-027 After rst deasserts, the first arbitration SHALL search from index 0.

Verification
REQ-028 Single requester: req=00100; done pulsed 3 cycles after grant -> gnt=00100 at t+1, gnt_id=2, then gnt=0 for 2 cycles.
REQ-029 Round robin: req=11111 held; each grant released after 1 cycle -> grant order 0,1,2,3,4,0.
REQ-030 Timeout with TIMEOUT=16: req=00001 held, no done -> gnt held for 16 cycles, then timeout_pulse=1 for 1 cycle, then requester 0 re-granted.
REQ-031 Collision: done[gnt_id] at cnt=15 with TIMEOUT=16 -> RELEASE, timeout_pulse=0.
REQ-032 Stray and reset cases: done[3] while gnt_id=1 -> no effect; rst pulse mid-GRANT -> gnt=0 same cycle; next grant searches from index 0.
